// File: rtl/hazard_ctrl_if.sv
// Control bundle between the 5-stage pipeline and its hazard/sequencing
// controller. The pipeline side is the master; the controller is the slave.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // ID / Ex hazard inputs
  logic [4:0]       rs_id;
  logic [4:0]       rt_id;
  logic             USE_RS;
  logic             USE_RT;
  logic [4:0]       regwr_Ex;
  logic             REGWR_Ex;
  logic             MEM2REG_Ex;
  // Mem stage inputs
  logic             REDIRECT_Mem;
  logic             MEM_REQ;
  logic             MEM_READY;
  // Pipeline register controls
  logic             PC_WE;
  logic             PC_SEL;
  logic             IFID_WE;
  logic             IFID_FLUSH;
  logic             IDEX_WE;
  logic             IDEX_FLUSH;
  logic             EXMEM_WE;
  logic             JUMPEN;
  // Status
  logic             mem_err;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output rs_id, rt_id, USE_RS, USE_RT, regwr_Ex, REGWR_Ex, MEM2REG_Ex,
    output REDIRECT_Mem, MEM_REQ, MEM_READY,
    input  PC_WE, PC_SEL, IFID_WE, IFID_FLUSH, IDEX_WE, IDEX_FLUSH,
    input  EXMEM_WE, JUMPEN, mem_err, state_o, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs_id, rt_id, USE_RS, USE_RT, regwr_Ex, REGWR_Ex, MEM2REG_Ex,
    input  REDIRECT_Mem, MEM_REQ, MEM_READY,
    output PC_WE, PC_SEL, IFID_WE, IFID_FLUSH, IDEX_WE, IDEX_FLUSH,
    output EXMEM_WE, JUMPEN, mem_err, state_o, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, Mem-stage redirects,
// whole-pipe freeze while data memory is busy (with timeout to ERR), and
// saturating stall/flush statistics.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  // One spare value of headroom so wait_cnt + 1 never wraps before compare.
  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 2);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               mem_err_q, mem_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic freeze;
  logic load_use;
  logic pc_we, pc_sel, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, jumpen;

  // State and statistics registers.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Hazard detection, pipeline controls, FSM next state and counter updates.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    pc_we       = 1'b1;
    pc_sel      = 1'b0;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_we     = 1'b1;
    idex_flush  = 1'b0;
    exmem_we    = 1'b1;
    jumpen      = 1'b0;

    freeze = ((state_q == ST_RUN)      && bus.MEM_REQ && !bus.MEM_READY) ||
             ((state_q == ST_MEM_WAIT) && !bus.MEM_READY) ||
             (state_q == ST_ERR);

    // A load to r0 never hazards; an rs==rt match is a single event.
    load_use = bus.MEM2REG_Ex && bus.REGWR_Ex && (bus.regwr_Ex != 5'd0) &&
               ((bus.USE_RS && (bus.rs_id == bus.regwr_Ex)) ||
                (bus.USE_RT && (bus.rt_id == bus.regwr_Ex)));

    // Pipeline controls: freeze > redirect > load-use > free-running.
    if (freeze) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else if (bus.REDIRECT_Mem) begin
      // The instruction a load-use would stall is squashed here anyway.
      pc_sel     = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      jumpen     = 1'b1;
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (load_use) begin
      // Hold PC and IF/ID, inject one bubble into ID/Ex; the load moves on.
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // Memory-wait sequencing.
    unique case (state_q)
      ST_RUN: begin
        if (bus.MEM_REQ && !bus.MEM_READY) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (bus.MEM_READY) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (wait_cnt_d >= TIMEOUT_V) begin
            state_d   = ST_ERR;
            mem_err_d = 1'b1;
          end
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase

    // Hold every register enable low while reset is asserted.
    if (!rst_n) begin
      pc_we      = 1'b0;
      pc_sel     = 1'b0;
      ifid_we    = 1'b0;
      ifid_flush = 1'b0;
      idex_we    = 1'b0;
      idex_flush = 1'b0;
      exmem_we   = 1'b0;
      jumpen     = 1'b0;
    end
  end

  assign bus.PC_WE      = pc_we;
  assign bus.PC_SEL     = pc_sel;
  assign bus.IFID_WE    = ifid_we;
  assign bus.IFID_FLUSH = ifid_flush;
  assign bus.IDEX_WE    = idex_we;
  assign bus.IDEX_FLUSH = idex_flush;
  assign bus.EXMEM_WE   = exmem_we;
  assign bus.JUMPEN     = jumpen;
  assign bus.mem_err    = mem_err_q;
  assign bus.state_o    = state_q;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the rules.
module tb_hazard_ctrl;
  localparam int T    = 4;
  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  // Behavioural model: consecutive frozen cycles of the current access,
  // sticky error, and plain integer counters.
  int m_wait;
  bit m_err;
  int m_stall;
  int m_flush;

  hazard_ctrl_if #(.CNT_W(CW)) bus ();

  hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, what, obs, exp);
    end
  endtask

  task automatic apply(input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt,
                       input logic [4:0] rd, input logic wr, input logic ld,
                       input logic rdr, input logic req, input logic rdy);
    bus.rs_id        = rs;
    bus.rt_id        = rt;
    bus.USE_RS       = urs;
    bus.USE_RT       = urt;
    bus.regwr_Ex     = rd;
    bus.REGWR_Ex     = wr;
    bus.MEM2REG_Ex   = ld;
    bus.REDIRECT_Mem = rdr;
    bus.MEM_REQ      = req;
    bus.MEM_READY    = rdy;
  endtask

  task automatic idle();
    apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic bit m_frozen();
    if (m_err) return 1'b1;
    if (m_wait == 0) return bus.MEM_REQ && !bus.MEM_READY;
    return !bus.MEM_READY;
  endfunction

  function automatic bit m_load_use();
    bit hit_rs, hit_rt;
    if (!(bus.MEM2REG_Ex && bus.REGWR_Ex) || bus.regwr_Ex == 5'd0) return 1'b0;
    hit_rs = bus.USE_RS && (bus.rs_id == bus.regwr_Ex);
    hit_rt = bus.USE_RT && (bus.rt_id == bus.regwr_Ex);
    return hit_rs || hit_rt;
  endfunction

  // Expected {PC_WE,PC_SEL,IFID_WE,IFID_FLUSH,IDEX_WE,IDEX_FLUSH,EXMEM_WE,JUMPEN}.
  function automatic logic [7:0] exp_ctrl();
    if (!rst_n)            return 8'b0000_0000;
    if (m_frozen())        return 8'b0000_0000;
    if (bus.REDIRECT_Mem)  return 8'b1111_1111;
    if (m_load_use())      return 8'b0000_1110;
    return 8'b1010_1010;
  endfunction

  function automatic logic [7:0] obs_ctrl();
    return {bus.PC_WE, bus.PC_SEL, bus.IFID_WE, bus.IFID_FLUSH,
            bus.IDEX_WE, bus.IDEX_FLUSH, bus.EXMEM_WE, bus.JUMPEN};
  endfunction

  function automatic int exp_state();
    if (m_err) return 2;
    return (m_wait > 0) ? 1 : 0;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  task automatic model_reset();
    m_wait  = 0;
    m_err   = 1'b0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // Advance the model across one rising edge using the inputs held there.
  task automatic model_update();
    if (m_frozen()) begin
      m_stall = sat_inc(m_stall);
      if (!m_err) begin
        if (m_wait > 0) begin
          m_wait++;
          if (m_wait >= T) m_err = 1'b1;
        end else begin
          m_wait = 1;
        end
      end
    end else begin
      m_wait = 0;
      if (bus.REDIRECT_Mem)   m_flush = sat_inc(m_flush);
      else if (m_load_use())  m_stall = sat_inc(m_stall);
    end
  endtask

  task automatic check_all(input string tag);
    check(tag, "ctrl",      32'(obs_ctrl()),      32'(exp_ctrl()));
    check(tag, "state_o",   32'(bus.state_o),     32'(exp_state()));
    check(tag, "mem_err",   32'(bus.mem_err),     32'(m_err));
    check(tag, "stall_cnt", 32'(bus.stall_cnt),   32'(m_stall));
    check(tag, "flush_cnt", 32'(bus.flush_cnt),   32'(m_flush));
  endtask

  // Inputs are already applied (just after a rising edge); check mid-cycle,
  // then take the next edge and advance the model.
  task automatic cycle(input string tag);
    #2;
    check_all(tag);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset(input string tag);
    idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    model_reset();
    idle();

    // Reset state.
    do_reset("por");

    // Load-use on rs: exactly one bubble, then free-running.
    apply(5'd3, 5'd7, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("lu_rs");
    apply(5'd3, 5'd7, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("lu_rs_next");
    check("lu_rs", "stall_is_1", 32'(bus.stall_cnt), 32'd1);

    // Load-use on rt, rs==rt double match counts once.
    apply(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("lu_both");
    idle();
    cycle("lu_both_next");

    // No stall: load to r0, and rs match with USE_RS=0.
    do_reset("rst_nostall");
    apply(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("ld_r0");
    apply(5'd3, 5'd4, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("no_use_rs");
    apply(5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("not_load");
    idle();
    cycle("nostall_end");
    check("nostall", "stall_is_0", 32'(bus.stall_cnt), 32'd0);

    // Redirect wins over a simultaneous load-use.
    do_reset("rst_redir");
    apply(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle("redir_lu");
    idle();
    cycle("redir_after");
    check("redir", "flush_is_1", 32'(bus.flush_cnt), 32'd1);
    check("redir", "stall_is_0", 32'(bus.stall_cnt), 32'd0);

    // Three frozen cycles with a held redirect, applied on release.
    do_reset("rst_wait");
    for (int i = 0; i < 3; i++) begin
      apply(5'd1, 5'd2, 1'b1, 1'b1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle("wait_frozen");
    end
    check("wait", "state_is_1", 32'(bus.state_o), 32'd1);
    apply(5'd1, 5'd2, 1'b1, 1'b1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    cycle("wait_release");
    idle();
    cycle("wait_after");
    check("wait", "state_is_0", 32'(bus.state_o), 32'd0);
    check("wait", "stall_is_3", 32'(bus.stall_cnt), 32'd3);

    // Timeout into ERR, which ignores MEM_READY until reset.
    do_reset("rst_tmo");
    for (int i = 0; i < T; i++) begin
      apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle("tmo_frozen");
    end
    check("tmo", "state_is_2", 32'(bus.state_o), 32'd2);
    check("tmo", "err_is_1",   32'(bus.mem_err), 32'd1);
    for (int i = 0; i < 3; i++) begin
      apply(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      cycle("err_hold");
    end
    do_reset("rst_after_err");
    check("err_cleared", "state_is_0", 32'(bus.state_o), 32'd0);

    // Counter saturation: five load-use bubbles.
    for (int i = 0; i < 5; i++) begin
      apply(5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle("sat_lu");
      idle();
      cycle("sat_gap");
    end
    check("sat", "stall_is_3", 32'(bus.stall_cnt), 32'd3);

    // Asynchronous reset in the middle of a memory wait.
    do_reset("rst_async");
    for (int i = 0; i < 2; i++) begin
      apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      cycle("async_wait");
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_in_rst");
    check("async_in_rst", "state_is_0", 32'(bus.state_o), 32'd0);
    do_reset("async_release");

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset("rnd_rst");
      end else begin
        apply(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 99) < 15),
              1'($urandom_range(0, 99) < 30),
              1'($urandom_range(0, 99) < 65));
        cycle("rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. It owns the IF/ID, ID/Ex and Ex/Mem register enables and flushes. It detects load-use hazards against the instruction in Ex and applies taken-branch/jump redirects resolved in Mem. It also freezes the whole pipe while the data memory is busy, with a timeout error state and saturating stall/flush statistics counters. Register-to-register forwarding stays inside the Ex stage; this block only handles what forwarding cannot.

Parameters:
MEM_TIMEOUT, 16, frozen cycles in MEM_WAIT before entering ERR (≥1)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
rs_id  in  5  rs field of instruction in ID
rt_id  in  5  rt field of instruction in ID
USE_RS  in  1  ID instruction reads rs
USE_RT  in  1  ID instruction reads rt
regwr_Ex  in  5  destination register of instruction in Ex
REGWR_Ex  in  1  Ex instruction writes a register
MEM2REG_Ex  in  1  Ex instruction is a load
REDIRECT_Mem  in  1  taken branch/jump resolved in Mem this cycle
MEM_REQ  in  1  Mem stage is accessing data memory
MEM_READY  in  1  data memory completes the access this cycle
PC_WE  out  1  PC update enable
PC_SEL  out  1  1 = PC loads the redirect target from Mem
IFID_WE  out  1  IF/ID register enable
IFID_FLUSH  out  1  IF/ID register loads a NOP
IDEX_WE  out  1  ID/Ex register enable
IDEX_FLUSH  out  1  ID/Ex register loads a bubble (all controls 0)
EXMEM_WE  out  1  Ex/Mem register enable
JUMPEN  out  1  kills MEMWR/REGWR of the instruction entering Ex/Mem
mem_err  out  1  sticky, memory timeout occurred
state_o  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 ERR
stall_cnt  out  CNT_W  bubble and frozen cycles, saturating
flush_cnt  out  CNT_W  redirect events, saturating

Behaviour:
- Registered state: state, wait_cnt, mem_err, stall_cnt, flush_cnt. All other outputs are combinational from state and inputs.
- Async reset (rst_n=0): state=RUN, wait_cnt=0, mem_err=0, counters=0. While rst_n=0, force PC_WE=IFID_WE=IDEX_WE=EXMEM_WE=0 and all flush/select outputs 0.
- Default (no event): all WE=1; PC_SEL, flushes and JUMPEN=0.
- freeze = (state==RUN && MEM_REQ && !MEM_READY) || (state==MEM_WAIT && !MEM_READY) || state==ERR.
  - When freeze is set: all four WE=0, all flushes, PC_SEL and JUMPEN=0. Redirect and load-use are ignored; Mem is frozen, so REDIRECT_Mem stays stable and is acted on after release.
  - stall_cnt increments on every freeze cycle.
- Redirect (not frozen, REDIRECT_Mem=1): PC_SEL=1, IFID_FLUSH=1, IDEX_FLUSH=1, JUMPEN=1, all WE=1. flush_cnt increments. It has priority over load-use in the same cycle (the stalled instruction is squashed anyway).
- Load-use (not frozen, no redirect): fires when MEM2REG_Ex && REGWR_Ex && regwr_Ex!=0 && ((USE_RS && rs_id==regwr_Ex) || (USE_RT && rt_id==regwr_Ex)).
  - Outputs: PC_WE=0, IFID_WE=0, IDEX_FLUSH=1, EXMEM_WE=1.
  - Exactly one bubble: the next cycle the load is in Mem, so the condition clears naturally.
  - stall_cnt increments.
- A load to r0 never stalls. An rs==rt match counts once.
- FSM transitions:
  - RUN → MEM_WAIT when MEM_REQ && !MEM_READY; wait_cnt becomes 1.
  - MEM_WAIT, MEM_READY=1: the release cycle is not frozen and normal redirect/load-use rules apply. Next state is RUN, wait_cnt=0.
  - MEM_WAIT, MEM_READY=0: wait_cnt increments. When wait_cnt reaches MEM_TIMEOUT, go to ERR and set mem_err=1.
  - ERR: permanent freeze; leaves only on reset. MEM_READY is ignored.
- Counters saturate at all-ones and never wrap.
- A reset asserted mid-MEM_WAIT or mid-stall returns to RUN immediately; pending redirects are dropped.

Test Plan:
- Ex: load, regwr_Ex=3. ID: add with rs_id=3, USE_RS=1 → exactly 1 cycle of PC_WE=0, IFID_WE=0, IDEX_FLUSH=1; next cycle all WE=1; stall_cnt=1.
- Same as above but regwr_Ex=0, or USE_RS=0 with rt_id≠3 → no stall, stall_cnt=0.
- REDIRECT_Mem=1 coinciding with a load-use match → same cycle PC_SEL=1, IFID_FLUSH=1, IDEX_FLUSH=1, JUMPEN=1, PC_WE=1; flush_cnt=1, stall_cnt=0.
- MEM_REQ=1 with MEM_READY=0 for 3 cycles, then 1 → 3 frozen cycles (all WE=0), state_o=1 during the wait, release on the 4th cycle with state_o=0; stall_cnt=3. A REDIRECT_Mem held throughout is applied on the release cycle.
- MEM_TIMEOUT=4, MEM_READY never asserted → state_o=2 and mem_err=1 after the 4th frozen cycle. Stays frozen even if MEM_READY later goes 1, until rst_n pulses low.
- CNT_W=2: 5 load-use bubbles → stall_cnt=3 (saturated). Async reset mid-MEM_WAIT → state_o=0, counters=0, WE=0 while reset is asserted.
